// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between the execute datapath (port 0)
// and the branch/jump address unit (port 1). Define ALU_ARB_STATS_EN to build the statistics counters.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_op0,
    input  logic [3:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data0,
    output logic [WIDTH-1:0] rsp_data1,
    output logic [1:0]       rsp_zero,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [3:0] IDLE_OP = 4'b0011;

    logic             r_prio;
    logic [1:0]       r_rspValid;
    logic [WIDTH-1:0] r_rspData0;
    logic [WIDTH-1:0] r_rspData1;
    logic [1:0]       r_rspZero;

    logic [1:0]       w_free;
    logic [1:0]       w_elig;
    logic [1:0]       w_loserMask;
    logic             w_conflict;
    logic             w_grant;
    logic             w_winner;

    // Eligibility is gated by reset so the ALU sees the idle drive while rst_n is low.
    assign w_free      = ~r_rspValid | rsp_ready;
    assign w_elig      = req_valid & w_free & {2{rst_n}};
    assign w_conflict  = &w_elig;
    assign w_grant     = |w_elig;
    assign w_winner    = w_conflict ? r_prio : ~w_elig[0];
    assign w_loserMask = w_conflict ? (r_prio ? 2'b01 : 2'b10) : 2'b00;
    assign req_ready   = w_free & {2{rst_n}} & ~w_loserMask;

    always_comb begin
        alu_op = IDLE_OP;
        alu_a  = '0;
        alu_b  = '0;
        if (w_grant) begin
            if (w_winner) begin
                alu_op = req_op1;
                alu_a  = req_a1;
                alu_b  = req_b1;
            end else begin
                alu_op = req_op0;
                alu_a  = req_a0;
                alu_b  = req_b0;
            end
        end
    end

    // A new grant takes precedence over a drain, which keeps back-to-back ops at full rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio     <= 1'b0;
            r_rspValid <= 2'b00;
            r_rspData0 <= '0;
            r_rspData1 <= '0;
            r_rspZero  <= 2'b00;
        end else begin
            if (w_grant) begin
                r_prio <= ~w_winner;
            end
            if (w_grant && !w_winner) begin
                r_rspValid[0] <= 1'b1;
                r_rspData0    <= alu_result;
                r_rspZero[0]  <= alu_zero;
            end else if (r_rspValid[0] && rsp_ready[0]) begin
                r_rspValid[0] <= 1'b0;
            end
            if (w_grant && w_winner) begin
                r_rspValid[1] <= 1'b1;
                r_rspData1    <= alu_result;
                r_rspZero[1]  <= alu_zero;
            end else if (r_rspValid[1] && rsp_ready[1]) begin
                r_rspValid[1] <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_data0 = r_rspData0;
    assign rsp_data1 = r_rspData1;
    assign rsp_zero  = r_rspZero;

`ifdef ALU_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_grantCnt0;
    logic [CNT_W-1:0] r_grantCnt1;
    logic [CNT_W-1:0] r_conflictCnt;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grantCnt0   <= '0;
            r_grantCnt1   <= '0;
            r_conflictCnt <= '0;
        end else begin
            if (w_grant && !w_winner && (r_grantCnt0 != '1)) begin
                r_grantCnt0 <= r_grantCnt0 + CNT_ONE;
            end
            if (w_grant && w_winner && (r_grantCnt1 != '1)) begin
                r_grantCnt1 <= r_grantCnt1 + CNT_ONE;
            end
            if (w_conflict && (r_conflictCnt != '1)) begin
                r_conflictCnt <= r_conflictCnt + CNT_ONE;
            end
        end
    end

    assign grant_cnt0   = r_grantCnt0;
    assign grant_cnt1   = r_grantCnt1;
    assign conflict_cnt = r_conflictCnt;
`else
    assign grant_cnt0   = '0;
    assign grant_cnt1   = '0;
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random traffic,
// compared against a transaction-level model of the two ports and the turn-taking rule.
module tb_alu_arbiter;

   localparam int WIDTH = 32;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [3:0]       req_op0, req_op1;
   logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_a, alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [WIDTH-1:0] rsp_data0, rsp_data1;
   logic [1:0]       rsp_zero;
   logic [CNT_W-1:0] grant_cnt0, grant_cnt1, conflict_cnt;

   int nChecks = 0;
   int nFail   = 0;

   // Reference model: what each port is holding, who was served last, and the statistics.
   bit               mValid [2];
   logic [WIDTH-1:0] mData [2];
   bit               mZero [2];
   int               lastServed;
   int               mGrants [2];
   int               mConflicts;

   logic [3:0] opList [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

   alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op0(req_op0), .req_op1(req_op1),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data0(rsp_data0), .rsp_data1(rsp_data1), .rsp_zero(rsp_zero),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural ALU standing in for the real ALU / alu_control pair.
   function automatic logic [WIDTH-1:0] aluFn(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
         4'b1100: return ~(a | b);
         default: return '0;
      endcase
   endfunction

   assign alu_result = aluFn(alu_op, alu_a, alu_b);
   assign alu_zero   = (alu_result == '0);

   // Every comparison funnels through here so the counts stay in one place.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nChecks++;
      assert (observed === expected)
      else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mValid[i]  = 0;
         mData[i]   = '0;
         mZero[i]   = 0;
         mGrants[i] = 0;
      end
      mConflicts = 0;
      lastServed = 1;
   endtask

   task automatic checkCounters();
`ifdef ALU_ARB_STATS_EN
      checkOutput("grant_cnt0", grant_cnt0, 64'(mGrants[0]));
      checkOutput("grant_cnt1", grant_cnt1, 64'(mGrants[1]));
      checkOutput("conflict_cnt", conflict_cnt, 64'(mConflicts));
`else
      checkOutput("grant_cnt0", grant_cnt0, 64'd0);
      checkOutput("grant_cnt1", grant_cnt1, 64'd0);
      checkOutput("conflict_cnt", conflict_cnt, 64'd0);
`endif
   endtask

   task automatic checkRegisters();
      checkOutput("rsp_valid", rsp_valid, {62'd0, mValid[1], mValid[0]});
      checkOutput("rsp_data0", rsp_data0, 64'(mData[0]));
      checkOutput("rsp_data1", rsp_data1, 64'(mData[1]));
      checkOutput("rsp_zero", rsp_zero, {62'd0, mZero[1], mZero[0]});
      checkCounters();
   endtask

   // Drives one cycle of requests starting just after a rising edge, checks the combinational
   // outputs mid-cycle, then advances the model across the edge and checks the registers.
   task automatic applyStimulus(input logic [1:0] v, input logic [1:0] rr,
                                input logic [3:0] o0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                                input logic [3:0] o1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
      bit       canTake [2];
      bit       wants [2];
      int       winner;
      logic [1:0] expReady;
      logic [3:0] ops [2];
      logic [WIDTH-1:0] as [2];
      logic [WIDTH-1:0] bs [2];
      logic [WIDTH-1:0] res;
      req_valid = v; rsp_ready = rr;
      req_op0 = o0; req_a0 = a0; req_b0 = b0;
      req_op1 = o1; req_a1 = a1; req_b1 = b1;
      ops[0] = o0; as[0] = a0; bs[0] = b0;
      ops[1] = o1; as[1] = a1; bs[1] = b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         canTake[i] = !mValid[i] || rr[i];
         wants[i]   = v[i] && canTake[i];
      end
      if (wants[0] && wants[1]) winner = 1 - lastServed;
      else if (wants[0])        winner = 0;
      else if (wants[1])        winner = 1;
      else                      winner = -1;
      for (int i = 0; i < 2; i++) begin
         expReady[i] = canTake[i] && !(wants[0] && wants[1] && winner != i);
      end
      checkOutput("req_ready", req_ready, 64'(expReady));
      if (winner >= 0) begin
         checkOutput("alu_op", alu_op, 64'(ops[winner]));
         checkOutput("alu_a", alu_a, 64'(as[winner]));
         checkOutput("alu_b", alu_b, 64'(bs[winner]));
      end else begin
         checkOutput("alu_op_idle", alu_op, 64'h3);
         checkOutput("alu_a_idle", alu_a, 64'd0);
      end
      @(posedge clk);
      #1;
      if (wants[0] && wants[1] && mConflicts < 65535) mConflicts++;
      for (int i = 0; i < 2; i++) begin
         if (winner == i) begin
            res       = aluFn(ops[i], as[i], bs[i]);
            mValid[i] = 1;
            mData[i]  = res;
            mZero[i]  = (res == '0);
            if (mGrants[i] < 65535) mGrants[i]++;
         end else if (mValid[i] && rr[i]) begin
            mValid[i] = 0;
         end
      end
      if (winner >= 0) lastServed = winner;
      checkRegisters();
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb, rc, rd;
      modelReset();
      rst_n = 1'b0;
      req_valid = 2'b11; rsp_ready = 2'b00;
      req_op0 = 4'b0010; req_a0 = 32'd1; req_b0 = 32'd2;
      req_op1 = 4'b0110; req_a1 = 32'd3; req_b1 = 32'd4;

      // Reset holds the handshake closed and the ALU on its idle drive.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_req_ready", req_ready, 64'd0);
      checkOutput("reset_alu_op", alu_op, 64'h3);
      checkOutput("reset_alu_b", alu_b, 64'd0);
      checkRegisters();
      rst_n = 1'b1;

      // Contention straight out of reset: port 0 first, then alternation.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(2'b11, 2'b11, 4'b0010, 32'(k), 32'd10, 4'b0001, 32'(k * 3), 32'h100);
      end

      // Single-port ADD with a one-cycle response, then a drain.
      applyStimulus(2'b01, 2'b11, 4'b0010, 32'd5, 32'd7, 4'b0000, 32'd0, 32'd0);
      checkOutput("add_result", rsp_data0, 64'd12);
      applyStimulus(2'b00, 2'b11, 4'b0000, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0);

      // Port 1 SUB to zero held under backpressure while port 0 keeps the ALU busy.
      applyStimulus(2'b10, 2'b01, 4'b0000, 32'd0, 32'd0, 4'b0110, 32'd9, 32'd9);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(2'b11, 2'b01, 4'b0010, 32'(k + 1), 32'd1, 4'b0010, 32'd1, 32'd1);
      end
      checkOutput("held_zero", rsp_zero[1], 64'd1);
      applyStimulus(2'b00, 2'b11, 4'b0000, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0);

      // Back-to-back AND/OR on port 0 keeps the response valid every cycle.
      for (int k = 0; k < 6; k++) begin
         ra = $urandom; rb = $urandom;
         applyStimulus(2'b01, 2'b01, (k % 2 == 0) ? 4'b0000 : 4'b0001, ra, rb, 4'b0000, 32'd0, 32'd0);
      end

      // Random traffic, with equal operands now and then to exercise the zero flag.
      for (int k = 0; k < 400; k++) begin
         ra = $urandom; rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         rc = $urandom; rd = ($urandom_range(0, 3) == 0) ? rc : $urandom;
         applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       opList[$urandom_range(0, 5)], ra, rb,
                       opList[$urandom_range(0, 5)], rc, rd);
      end

      // Fill both response registers, then reset asynchronously between edges.
      applyStimulus(2'b00, 2'b11, 4'b0000, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0);
      applyStimulus(2'b01, 2'b00, 4'b0010, 32'd20, 32'd22, 4'b0000, 32'd0, 32'd0);
      applyStimulus(2'b10, 2'b00, 4'b0000, 32'd0, 32'd0, 4'b0110, 32'd50, 32'd8);
      checkOutput("both_full", rsp_valid, 64'd3);
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("async_req_ready", req_ready, 64'd0);
      checkRegisters();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // After reset the turn order starts from port 0 again.
      applyStimulus(2'b11, 2'b11, 4'b0001, 32'hF0, 32'h0F, 4'b0010, 32'd1, 32'd1);
      applyStimulus(2'b11, 2'b11, 4'b0001, 32'h1, 32'h2, 4'b0010, 32'd2, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
      $finish;
   end

endmodule
